// File: rtl/quad_pkg.sv
// Shared types and Gray-code phase ordering for the quadrature step decoder.
package quad_pkg;

    typedef logic [1:0] phase_t;

    typedef enum logic [0:0] {
        SEED  = 1'b0,
        TRACK = 1'b1
    } fsm_t;

    // Clockwise phase sequence {A, B}: 00 -> 10 -> 11 -> 01 -> 00
    localparam phase_t CW_PH0 = 2'b00;
    localparam phase_t CW_PH1 = 2'b10;
    localparam phase_t CW_PH2 = 2'b11;
    localparam phase_t CW_PH3 = 2'b01;

    // Phase reached by one clockwise step from p
    function automatic phase_t next_cw(input phase_t p);
        phase_t n;
        case (p)
            CW_PH0:  n = CW_PH1;
            CW_PH1:  n = CW_PH2;
            CW_PH2:  n = CW_PH3;
            default: n = CW_PH0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Two-flop synchronizer plus persistence filter for one raw encoder line.
// 'settled' is sticky: set once the line has accepted a level or has matched
// the filtered level for FILTER_CYCLES consecutive cycles.
module quad_input_filter #(
    parameter int unsigned FILTER_CYCLES = 50_000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic filt,
    output logic settled
);

    localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             filt_q, filt_d;
    logic             settled_q, settled_d;
    logic [CNT_W-1:0] diff_cnt_q, diff_cnt_d;
    logic [CNT_W-1:0] same_cnt_q, same_cnt_d;

    // Synchronize the asynchronous pin into the clk domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreement (accept) and agreement (settle) cycles
    always_comb begin
        filt_d     = filt_q;
        settled_d  = settled_q;
        diff_cnt_d = '0;
        same_cnt_d = same_cnt_q;
        if (sync2_q != filt_q) begin
            same_cnt_d = '0;
            if (diff_cnt_q == CNT_LAST) begin
                filt_d    = sync2_q;
                settled_d = 1'b1;
            end else begin
                diff_cnt_d = diff_cnt_q + CNT_W'(1);
            end
        end else if (!settled_q) begin
            if (same_cnt_q == CNT_LAST) begin
                settled_d = 1'b1;
            end else begin
                same_cnt_d = same_cnt_q + CNT_W'(1);
            end
        end
    end

    // Filter state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q     <= 1'b0;
            settled_q  <= 1'b0;
            diff_cnt_q <= '0;
            same_cnt_q <= '0;
        end else begin
            filt_q     <= filt_d;
            settled_q  <= settled_d;
            diff_cnt_q <= diff_cnt_d;
            same_cnt_q <= same_cnt_d;
        end
    end

    assign filt    = filt_q;
    assign settled = settled_q;

endmodule

// File: rtl/quadrature_step_decoder.sv
// Rotary encoder front-end: filters A/B, decodes Gray-code phase steps and
// emits one registered pulse per completed detent, or an error pulse on a
// double-bit phase jump.
module quadrature_step_decoder
    import quad_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES     = 50_000,
    parameter int unsigned COUNTS_PER_DETENT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic A,
    input  logic B,
    output logic clockwise,
    output logic counterclockwise,
    output logic error
);

    localparam int unsigned ACC_W = $clog2(COUNTS_PER_DETENT) + 2;
    localparam logic signed [ACC_W-1:0] ACC_POS = ACC_W'(COUNTS_PER_DETENT);
    localparam logic signed [ACC_W-1:0] ACC_NEG = -ACC_POS;

    logic   filt_a, filt_b;
    logic   settled_a, settled_b;
    phase_t cur_phase;

    fsm_t   state_q, state_d;
    phase_t phase_q, phase_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_step;
    logic   cw_q, cw_d;
    logic   ccw_q, ccw_d;
    logic   err_q, err_d;

    quad_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
        .clk     (clk),
        .reset   (reset),
        .din     (A),
        .filt    (filt_a),
        .settled (settled_a)
    );

    quad_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
        .clk     (clk),
        .reset   (reset),
        .din     (B),
        .filt    (filt_b),
        .settled (settled_b)
    );

    assign cur_phase = {filt_a, filt_b};

    // Seed/track FSM, step classification and detent accumulation
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        acc_d    = acc_q;
        acc_step = acc_q;
        cw_d     = 1'b0;
        ccw_d    = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            SEED: begin
                if (settled_a && settled_b) begin
                    phase_d = cur_phase;
                    acc_d   = '0;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (cur_phase != phase_q) begin
                    phase_d = cur_phase;
                    if (cur_phase == next_cw(phase_q)) begin
                        acc_step = acc_q + ACC_W'(1);
                    end else if (phase_q == next_cw(cur_phase)) begin
                        acc_step = acc_q - ACC_W'(1);
                    end else begin
                        err_d    = 1'b1;
                        acc_step = '0;
                    end
                    if (acc_step == ACC_POS) begin
                        cw_d  = 1'b1;
                        acc_d = '0;
                    end else if (acc_step == ACC_NEG) begin
                        ccw_d = 1'b1;
                        acc_d = '0;
                    end else begin
                        acc_d = acc_step;
                    end
                end
            end
            default: state_d = SEED;
        endcase
        // Disabled: phase keeps tracking so re-enabling cannot produce a stale step
        if (!enable) begin
            acc_d = '0;
            cw_d  = 1'b0;
            ccw_d = 1'b0;
            err_d = 1'b0;
        end
    end

    // Decoder state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEED;
            phase_q <= CW_PH0;
            acc_q   <= '0;
            cw_q    <= 1'b0;
            ccw_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            acc_q   <= acc_d;
            cw_q    <= cw_d;
            ccw_q   <= ccw_d;
            err_q   <= err_d;
        end
    end

    assign clockwise        = cw_q;
    assign counterclockwise = ccw_q;
    assign error            = err_q;

endmodule
